game_flow_ctrl: RTL and testbench

Top-level game sequencer for the cartridge: decodes the resistor-ladder joystick comparators and the start key, debounces them, and drives the game state machine (title, difficulty select, play, pause, end) plus the round countdown. It sits between the raw board inputs and the game/VGA rendering logic. It supplies state, difficulty, run-enable and timer values that the renderer and game logic consume each frame.

---
 rtl/game_flow_ctrl_pkg.sv | 16 +
 rtl/game_flow_ctrl_debounce.sv | 38 +++
 rtl/game_flow_ctrl.sv | 118 +++++++++++
 tb/tb_game_flow_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_flow_ctrl_pkg.sv
// game_flow_ctrl_pkg: shared encodings for the game sequencer
package game_flow_ctrl_pkg;
    typedef enum logic [2:0] {
        GAME_START = 3'b000,
        DIFF_SEL   = 3'b001,
        PLAYING    = 3'b010,
        GAME_END   = 3'b011,
        PAUSE      = 3'b100
    } state_t;
    localparam logic KEY_PRESS = 1'b1;
    localparam logic [1:0] AXIS_IDLE = 2'b00;
    localparam logic [1:0] AXIS_NEG  = 2'b01;
    localparam logic [1:0] AXIS_POS  = 2'b11;
    localparam logic [1:0] AXIS_BAD  = 2'b10;
    localparam int DIFF_W = 2;
endpackage

// File: rtl/game_flow_ctrl_debounce.sv
// debounce: optional 2-FF sync, hold-time filter and registered rise pulse
module debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit SYNC = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic prev;
    logic s;
    assign s = SYNC ? sync[1] : raw;
    // accept a new level only after it has disagreed with the current one long enough
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            prev  <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            prev <= level;
            rise <= level & ~prev;
            if (s == level) cnt <= '0;
            else if (cnt == LIMIT) begin
                level <= s;
                cnt   <= '0;
            end else cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: input conditioning and game state sequencer
module game_flow_ctrl
    import game_flow_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter logic [15:0] ROUND_FRAMES = 16'd3600,
    parameter logic [15:0] END_HOLD_FRAMES = 16'd120
) (
    input  logic              vga_clk,
    input  logic              sys_rst,
    input  logic              one_resistor_x,
    input  logic              two_resistors_x,
    input  logic              one_resistor_y,
    input  logic              two_resistors_y,
    input  logic              key_start,
    input  logic              frame_tick,
    input  logic              player_hit,
    output logic [2:0]        state,
    output logic [DIFF_W-1:0] difficulty,
    output logic [15:0]       round_timer,
    output logic              game_run,
    output logic              win,
    output logic              dir_left,
    output logic              dir_right,
    output logic              dir_up,
    output logic              dir_down,
    output logic              state_chg
);
    state_t st, nxt;
    logic [15:0] nxt_timer;
    logic nxt_win;
    logic [DIFF_W-1:0] nxt_diff;
    logic [3:0] cmp_s0, cmp_s1;
    logic [1:0] x_code, y_code;
    logic [3:0] dir_raw, dir_lvl, dir_rise;
    logic start_lvl, start_p;
    logic unused;
    // comparators are synchronized before decode so both ladder bits come from the same sample
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cmp_s0 <= '0;
            cmp_s1 <= '0;
        end else begin
            cmp_s0 <= {two_resistors_x, one_resistor_x, two_resistors_y, one_resistor_y};
            cmp_s1 <= cmp_s0;
        end
    end
    assign x_code = cmp_s1[3:2];
    assign y_code = cmp_s1[1:0];
    assign dir_raw = {x_code == AXIS_NEG, x_code == AXIS_POS, y_code == AXIS_NEG, y_code == AXIS_POS};
    for (genvar g = 0; g < 4; g++) begin : g_dir
        debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC(1'b0)) u_dir (
            .clk(vga_clk), .rst(sys_rst), .raw(dir_raw[g]), .level(dir_lvl[g]), .rise(dir_rise[g])
        );
    end
    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC(1'b1)) u_start (
        .clk(vga_clk), .rst(sys_rst), .raw(key_start == KEY_PRESS), .level(start_lvl), .rise(start_p)
    );
    assign unused = &{1'b0, start_lvl, dir_rise[3:2]};
    // next state, timer, win flag and difficulty from the priority-ordered transition rules
    always_comb begin
        nxt       = st;
        nxt_timer = round_timer;
        nxt_win   = win;
        nxt_diff  = difficulty;
        case (st)
            GAME_START: nxt = start_p ? DIFF_SEL : GAME_START;
            DIFF_SEL: begin
                if (dir_rise[1] && !dir_rise[0] && difficulty != 2'd3) nxt_diff = difficulty + 1'b1;
                if (dir_rise[0] && !dir_rise[1] && difficulty != 2'd0) nxt_diff = difficulty - 1'b1;
                if (start_p) begin
                    nxt       = PLAYING;
                    nxt_timer = ROUND_FRAMES;
                    nxt_win   = 1'b0;
                end
            end
            PLAYING: begin
                if (player_hit || (frame_tick && round_timer == 16'd1)) begin
                    nxt       = GAME_END;
                    nxt_win   = !player_hit;
                    nxt_timer = END_HOLD_FRAMES;
                end else begin
                    if (frame_tick && round_timer != '0) nxt_timer = round_timer - 16'd1;
                    if (start_p) nxt = PAUSE;
                end
            end
            PAUSE: nxt = start_p ? PLAYING : PAUSE;
            GAME_END: begin
                if (start_p && round_timer == '0) nxt = GAME_START;
                else if (frame_tick && round_timer != '0) nxt_timer = round_timer - 16'd1;
            end
            default: nxt = GAME_START;
        endcase
    end
    // register the sequencer state and every output that follows it
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            st          <= GAME_START;
            difficulty  <= '0;
            round_timer <= '0;
            win         <= 1'b0;
            game_run    <= 1'b0;
            state_chg   <= 1'b0;
        end else begin
            st          <= nxt;
            difficulty  <= nxt_diff;
            round_timer <= nxt_timer;
            win         <= nxt_win;
            game_run    <= nxt == PLAYING;
            state_chg   <= nxt != st;
        end
    end
    assign state     = st;
    assign dir_left  = dir_lvl[3] & game_run;
    assign dir_right = dir_lvl[2] & game_run;
    assign dir_up    = dir_lvl[1] & game_run;
    assign dir_down  = dir_lvl[0] & game_run;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed stimulus checked against a rule-level model
module tb_game_flow_ctrl;
    localparam int N = 4, RF = 5, EH = 3;
    logic vga_clk = 1'b0, sys_rst = 1'b1;
    logic one_resistor_x = 1'b0, two_resistors_x = 1'b0, one_resistor_y = 1'b0, two_resistors_y = 1'b0;
    logic key_start = 1'b0, frame_tick = 1'b0, player_hit = 1'b0;
    logic [2:0] state;
    logic [1:0] difficulty;
    logic [15:0] round_timer;
    logic game_run, win, dir_left, dir_right, dir_up, dir_down, state_chg;
    int vectors = 0, miscompares = 0;
    int m_state, m_diff, m_timer, m_win, m_chg;
    logic [4:0] rq1, rq2;
    logic [7:0] h [5];
    logic [7:0] dh [5];

    game_flow_ctrl #(.DEBOUNCE_CYCLES(N), .ROUND_FRAMES(16'(RF)), .END_HOLD_FRAMES(16'(EH))) dut (
        .vga_clk(vga_clk), .sys_rst(sys_rst),
        .one_resistor_x(one_resistor_x), .two_resistors_x(two_resistors_x),
        .one_resistor_y(one_resistor_y), .two_resistors_y(two_resistors_y),
        .key_start(key_start), .frame_tick(frame_tick), .player_hit(player_hit),
        .state(state), .difficulty(difficulty), .round_timer(round_timer),
        .game_run(game_run), .win(win), .dir_left(dir_left), .dir_right(dir_right),
        .dir_up(dir_up), .dir_down(dir_down), .state_chg(state_chg)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_diff = 0; m_timer = 0; m_win = 0; m_chg = 0;
        rq1 = '0; rq2 = '0;
        for (int i = 0; i < 5; i++) begin
            h[i] = '0;
            dh[i] = '0;
        end
    endtask

    // one clock edge of the game rules; lines are 0 left, 1 right, 2 up, 3 down, 4 start
    task automatic model_step();
        logic [4:0] seen;
        logic [7:0] mask;
        logic sp, up, dn, cur;
        int ns, nt, nw, nd;
        sp = dh[4][1] & ~dh[4][2];
        up = dh[2][1] & ~dh[2][2];
        dn = dh[3][1] & ~dh[3][2];
        ns = m_state; nt = m_timer; nw = m_win; nd = m_diff;
        if (m_state == 0) begin
            if (sp) ns = 1;
        end else if (m_state == 1) begin
            if (up && !dn) nd = (m_diff < 3) ? m_diff + 1 : 3;
            if (dn && !up) nd = (m_diff > 0) ? m_diff - 1 : 0;
            if (sp) begin ns = 2; nt = RF; nw = 0; end
        end else if (m_state == 2) begin
            if (player_hit) begin ns = 3; nw = 0; nt = EH; end
            else if (frame_tick && m_timer == 1) begin ns = 3; nw = 1; nt = EH; end
            else begin
                if (frame_tick && m_timer > 0) nt = m_timer - 1;
                if (sp) ns = 4;
            end
        end else if (m_state == 4) begin
            if (sp) ns = 2;
        end else if (m_state == 3) begin
            if (sp && m_timer == 0) ns = 0;
            else if (frame_tick && m_timer > 0) nt = m_timer - 1;
        end else ns = 0;
        m_chg = (ns != m_state);
        m_state = ns; m_timer = nt; m_win = nw; m_diff = nd;
        seen = {rq2[0], rq2[2:1] == 2'b11, rq2[2:1] == 2'b01, rq2[4:3] == 2'b11, rq2[4:3] == 2'b01};
        mask = 8'((1 << (N + 1)) - 1);
        for (int i = 0; i < 5; i++) begin
            h[i] = {h[i][6:0], seen[i]};
            cur = dh[i][0];
            if ((h[i] & mask) == (cur ? 8'h00 : mask)) cur = ~cur;
            dh[i] = {dh[i][6:0], cur};
        end
        rq2 = rq1;
        rq1 = {two_resistors_x, one_resistor_x, two_resistors_y, one_resistor_y, key_start};
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge vga_clk or posedge sys_rst);
            if (sys_rst) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(negedge vga_clk);
        if (!sys_rst) begin
            check("m_state", state, m_state);
            check("m_difficulty", difficulty, m_diff);
            check("m_round_timer", round_timer, m_timer);
            check("m_game_run", game_run, m_state == 2);
            check("m_win", win, m_win);
            check("m_state_chg", state_chg, m_chg);
            check("m_dir_left", dir_left, dh[0][0] & (m_state == 2));
            check("m_dir_right", dir_right, dh[1][0] & (m_state == 2));
            check("m_dir_up", dir_up, dh[2][0] & (m_state == 2));
            check("m_dir_down", dir_down, dh[3][0] & (m_state == 2));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge vga_clk);
    endtask

    task automatic press_start();
        key_start = 1'b1;
        cyc(8);
        key_start = 1'b0;
        cyc(10);
    endtask

    task automatic press_y(input logic [1:0] c);
        {two_resistors_y, one_resistor_y} = c;
        cyc(8);
        {two_resistors_y, one_resistor_y} = 2'b00;
        cyc(10);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        cyc(1);
    endtask

    initial begin
        cyc(3);
        check("rst_state", state, 0);
        check("rst_timer", round_timer, 0);
        check("rst_run", game_run, 0);
        check("rst_diff", difficulty, 0);
        check("rst_chg", state_chg, 0);
        sys_rst = 1'b0;
        key_start = 1'b1; cyc(3); key_start = 1'b0; cyc(12);
        check("glitch_state", state, 0);
        key_start = 1'b1;
        cyc(8);
        check("start_edge7", state, 0);
        cyc(1);
        check("start_edge8", state, 1);
        check("chg_pulse", state_chg, 1);
        cyc(1);
        key_start = 1'b0;
        check("chg_once", state_chg, 0);
        cyc(12);
        repeat (5) press_y(2'b01);
        check("diff_sat_hi", difficulty, 3);
        repeat (4) press_y(2'b11);
        check("diff_sat_lo", difficulty, 0);
        press_y(2'b01);
        check("diff_one", difficulty, 1);
        press_start();
        check("play_state", state, 2);
        check("play_timer", round_timer, 5);
        check("play_run", game_run, 1);
        {two_resistors_y, one_resistor_y} = 2'b11;
        {two_resistors_x, one_resistor_x} = 2'b01;
        cyc(9);
        check("dir_down_play", dir_down, 1);
        check("dir_left_play", dir_left, 1);
        check("dir_up_play", dir_up, 0);
        {two_resistors_y, one_resistor_y} = 2'b00;
        {two_resistors_x, one_resistor_x} = 2'b00;
        cyc(10);
        for (int i = 4; i >= 1; i--) begin
            tick();
            check("timer_count", round_timer, i);
        end
        tick();
        check("end_state", state, 3);
        check("end_win", win, 1);
        check("end_timer", round_timer, 3);
        press_start();
        check("early_start", state, 3);
        repeat (3) tick();
        check("hold_done", round_timer, 0);
        press_start();
        check("back_title", state, 0);
        check("diff_kept", difficulty, 1);
        {two_resistors_y, one_resistor_y} = 2'b11;
        cyc(10);
        check("dir_down_title", dir_down, 0);
        {two_resistors_y, one_resistor_y} = 2'b00;
        cyc(10);
        press_start();
        press_start();
        check("play_again", state, 2);
        {two_resistors_y, one_resistor_y} = 2'b10;
        {two_resistors_x, one_resistor_x} = 2'b11;
        cyc(20);
        check("bad_up", dir_up, 0);
        check("bad_down", dir_down, 0);
        check("dir_right_play", dir_right, 1);
        {two_resistors_y, one_resistor_y} = 2'b00;
        {two_resistors_x, one_resistor_x} = 2'b00;
        cyc(10);
        press_start();
        check("pause_state", state, 4);
        check("pause_run", game_run, 0);
        tick();
        tick();
        check("pause_frozen", round_timer, 5);
        player_hit = 1'b1; cyc(1); player_hit = 1'b0; cyc(1);
        check("pause_hit", state, 4);
        press_start();
        check("resume", state, 2);
        repeat (4) tick();
        check("timer_one", round_timer, 1);
        player_hit = 1'b1; frame_tick = 1'b1;
        cyc(1);
        player_hit = 1'b0; frame_tick = 1'b0;
        check("hit_state", state, 3);
        check("hit_win", win, 0);
        check("hit_timer", round_timer, 3);
        cyc(1);
        repeat (3) tick();
        press_start();
        press_start();
        press_start();
        check("play3_state", state, 2);
        tick();
        tick();
        check("timer_three", round_timer, 3);
        #2 sys_rst = 1'b1;
        #1;
        check("async_state", state, 0);
        check("async_timer", round_timer, 0);
        check("async_run", game_run, 0);
        cyc(2);
        sys_rst = 1'b0;
        cyc(5);
        check("post_rst_state", state, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
